// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the FSM state encodings, the UART byte width and a modulo
// increment helper for the round-robin pointer.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic [1:0] ST_DRAIN     = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ISSUE     = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // idx + 1, wrapping to 0 at n
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the requesters / uart_transmitter side and the
// arbiter.
//   req, req_data, req_last : per-requester byte offer (requester side)
//   ack, grant              : per-requester acceptance pulse / owner one-hot
//   err                     : timeout drop pulse
//   tx_en, tx_data, tx_busy : uart_transmitter handshake
// modport master : requesters + transmitter (drive req*, tx_busy)
// modport slave  : the arbiter
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req;
  logic [UART_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             grant;
  logic                           err;
  logic                           tx_en;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_busy;

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, grant, err, tx_en, tx_data
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, grant, err, tx_en, tx_data
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : first index to consider when unlocked
//   lock/owner : when locked only the owner may be picked
//   pick       : one-hot pick, pick_idx its index, pick_valid any pick
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               lock,
  input  logic [IDX_W-1:0]   owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  always_comb begin
    int unsigned j;
    j          = 0;
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    if (lock) begin
      if (req[owner]) begin
        pick[owner] = 1'b1;
        pick_idx    = owner;
        pick_valid  = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        j = 32'(ptr) + i;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!pick_valid && req[IDX_W'(j)]) begin
          pick[IDX_W'(j)] = 1'b1;
          pick_idx        = IDX_W'(j);
          pick_valid      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter between NUM_REQ
// requesters, with packet lock (owner keeps the UART until its req_last
// byte has gone out) and the tx_en/tx_busy handshake.
//   sys_clk, rst : clock, synchronous active-high reset
//   bus (slave)  : req/req_data/req_last in, ack/grant/err out,
//                  tx_en/tx_data out, tx_busy in
// Optional: define UART_ARB_TIMEOUT_EN to drop a byte when tx_busy does
// not rise within TIMEOUT_CYCLES cycles of ISSUE (err pulses). Without it
// ISSUE waits indefinitely and err is constant 0.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input logic             sys_clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]             state_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic                   tx_en_q;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       owner_q;
  logic                   lock_q;
  logic                   last_q;

  logic [NUM_REQ-1:0]     pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [UART_DATA_W-1:0] pick_byte;
  logic                   pick_last;
  logic [IDX_W-1:0]       next_owner;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (bus.req),
    .ptr        (ptr_q),
    .lock       (lock_q),
    .owner      (owner_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_comb begin
    pick_byte = '0;
    pick_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_byte = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
        pick_last = bus.req_last[i];
      end
    end
  end

  assign next_owner = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_DRAIN;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      last_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        ST_DRAIN: begin
          // A frame may still be in flight after reset
          if (!bus.tx_busy) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (lock_q && !bus.req[owner_q]) begin
            // Owner dropped its request mid-packet: abandon the packet
            lock_q  <= 1'b0;
            grant_q <= '0;
            ptr_q   <= next_owner;
          end else if (pick_valid) begin
            grant_q   <= pick;
            owner_q   <= pick_idx;
            tx_data_q <= pick_byte;
            last_q    <= pick_last;
            tx_en_q   <= 1'b1;
            state_q   <= ST_ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (bus.tx_busy) begin
            tx_en_q        <= 1'b0;
            ack_q[owner_q] <= 1'b1;
            state_q        <= ST_WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Transmitter never accepted: drop the byte and the packet
            tx_en_q        <= 1'b0;
            err_q          <= 1'b1;
            ack_q[owner_q] <= 1'b1;
            lock_q         <= 1'b0;
            grant_q        <= '0;
            ptr_q          <= next_owner;
            state_q        <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              lock_q  <= 1'b0;
              grant_q <= '0;
              ptr_q   <= next_owner;
            end else begin
              lock_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_DRAIN;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.ack     = ack_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule
